// File: rtl/pong_physics_if.sv
// Pixel-side bundle between the video timing / pixel mux and the pong physics engine.
// The master drives buttons and pixel coordinates; the slave (physics engine) returns flags and pulses.
interface pong_physics_if;
    logic [3:0] btn;
    logic       gra_still;
    logic [9:0] x;
    logic [9:0] y;
    logic       ball_on;
    logic       lpad_on;
    logic       rpad_on;
    logic       l_hit;
    logic       r_hit;
    logic       l_mis;
    logic       r_mis;
    logic [2:0] speed;

    modport master (
        output btn, gra_still, x, y,
        input  ball_on, lpad_on, rpad_on, l_hit, r_hit, l_mis, r_mis, speed
    );
    modport slave (
        input  btn, gra_still, x, y,
        output ball_on, lpad_on, rpad_on, l_hit, r_hit, l_mis, r_mis, speed
    );
endinterface

// File: rtl/pong_physics.sv
// Ball/paddle physics for the ping-pong pipeline: one update per frame tick, serve FSM,
// speed-up on repeated paddle hits, per-pixel object flags and one-cycle hit/miss pulses.
module pong_physics #(
    parameter int H_ACTIVE      = 640,
    parameter int TICK_Y        = 481,
    parameter int WALL_T        = 72,
    parameter int WALL_B        = 475,
    parameter int PAD_H         = 100,
    parameter int PAD_W         = 7,
    parameter int PAD_V         = 4,
    parameter int LPAD_X        = 32,
    parameter int RPAD_X        = 600,
    parameter int BALL_SIZE     = 8,
    parameter int SPD_INIT      = 1,
    parameter int SPD_MAX       = 6,
    parameter int HITS_PER_STEP = 4,
    parameter int SERVE_FRAMES  = 60
) (
    input  logic          clk,
    input  logic          reset,
    pong_physics_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SERVE, PLAY} state_e;

    localparam int HC_W = $clog2(HITS_PER_STEP + 1);
    localparam int SC_W = $clog2(SERVE_FRAMES);

    localparam logic [10:0] C_BS         = 11'(BALL_SIZE);
    localparam logic [10:0] C_PH         = 11'(PAD_H);
    localparam logic [10:0] C_PW         = 11'(PAD_W);
    localparam logic [10:0] C_PV         = 11'(PAD_V);
    localparam logic [10:0] C_WT         = 11'(WALL_T);
    localparam logic [10:0] C_WB         = 11'(WALL_B);
    localparam logic [10:0] C_LPAD_X     = 11'(LPAD_X);
    localparam logic [10:0] C_RPAD_X     = 11'(RPAD_X);
    localparam logic [10:0] C_L_FACE     = 11'(LPAD_X + PAD_W);
    localparam logic [10:0] C_R_FACE     = 11'(RPAD_X - 1);
    localparam logic [10:0] C_R_LAND     = 11'(RPAD_X - BALL_SIZE);
    localparam logic [10:0] C_X_EDGE     = 11'(H_ACTIVE - 1);
    localparam logic [10:0] C_BALL_X0    = 11'((H_ACTIVE - BALL_SIZE) / 2);
    localparam logic [10:0] C_BALL_Y0    = 11'((WALL_T + WALL_B + 1 - BALL_SIZE) / 2);
    localparam logic [10:0] C_PAD_Y0     = 11'((WALL_T + WALL_B + 1 - PAD_H) / 2);
    localparam logic [10:0] C_PAD_Y_MAX  = 11'(WALL_B - PAD_H + 1);
    localparam logic [10:0] C_BALL_Y_MAX = 11'(WALL_B - BALL_SIZE + 1);
    localparam logic [2:0]  C_SPD_INIT   = 3'(SPD_INIT);
    localparam logic [2:0]  C_SPD_MAX    = 3'(SPD_MAX);
    localparam logic [HC_W-1:0] C_HC_LAST  = HC_W'(HITS_PER_STEP - 1);
    localparam logic [SC_W-1:0] C_SC_LAST  = SC_W'(SERVE_FRAMES - 1);

    state_e           state_q, state_d;
    logic [9:0]       ball_x_q, ball_x_d, ball_y_q, ball_y_d;
    logic [9:0]       lpad_y_q, lpad_y_d, rpad_y_q, rpad_y_d;
    logic             dir_x_q, dir_x_d;          // 1 = moving right
    logic             dir_y_q, dir_y_d;          // 1 = moving down
    logic             serve_right_q, serve_right_d;
    logic [2:0]       speed_q, speed_d;
    logic [HC_W-1:0]  hit_cnt_q, hit_cnt_d;
    logic [SC_W-1:0]  serve_cnt_q, serve_cnt_d;
    logic             l_hit_q, l_hit_d, r_hit_q, r_hit_d, l_mis_q, l_mis_d, r_mis_q, r_mis_d;
    logic             hit, load_serve;

    logic        tick;
    logic [10:0] bx, by, lp, rp, spd, px, py;
    logic        l_ovl, r_ovl;

    assign tick  = (bus.y == 10'(TICK_Y)) && (bus.x == 10'd0);
    assign bx    = {1'b0, ball_x_q};
    assign by    = {1'b0, ball_y_q};
    assign lp    = {1'b0, lpad_y_q};
    assign rp    = {1'b0, rpad_y_q};
    assign spd   = {8'd0, speed_q};
    assign px    = {1'b0, bus.x};
    assign py    = {1'b0, bus.y};
    // Paddle overlap is judged on the ball rows before this frame's vertical move.
    assign l_ovl = (by + C_BS - 11'd1 >= lp) && (by <= lp + C_PH - 11'd1);
    assign r_ovl = (by + C_BS - 11'd1 >= rp) && (by <= rp + C_PH - 11'd1);

    function automatic logic [9:0] pad_step(input logic [9:0] pos, input logic up, input logic dn);
        logic [10:0] p;
        p = {1'b0, pos};
        pad_step = pos;
        if (up && !dn)      pad_step = (p < C_WT + C_PV) ? 10'(C_WT) : 10'(p - C_PV);
        else if (dn && !up) pad_step = (p + C_PV > C_PAD_Y_MAX) ? 10'(C_PAD_Y_MAX) : 10'(p + C_PV);
    endfunction

    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        state_d       = state_q;
        ball_x_d      = ball_x_q;
        ball_y_d      = ball_y_q;
        lpad_y_d      = lpad_y_q;
        rpad_y_d      = rpad_y_q;
        dir_x_d       = dir_x_q;
        dir_y_d       = dir_y_q;
        serve_right_d = serve_right_q;
        speed_d       = speed_q;
        hit_cnt_d     = hit_cnt_q;
        serve_cnt_d   = serve_cnt_q;
        l_hit_d       = 1'b0;
        r_hit_d       = 1'b0;
        l_mis_d       = 1'b0;
        r_mis_d       = 1'b0;
        hit           = 1'b0;
        load_serve    = 1'b0;

        if (tick) begin
            lpad_y_d = pad_step(lpad_y_q, bus.btn[2], bus.btn[3]);
            rpad_y_d = pad_step(rpad_y_q, bus.btn[0], bus.btn[1]);
            if (bus.gra_still) begin
                state_d  = IDLE;
                ball_x_d = 10'(C_BALL_X0);
                ball_y_d = 10'(C_BALL_Y0);
            end else begin
                case (state_q)
                    IDLE: begin
                        state_d     = SERVE;
                        serve_cnt_d = '0;
                        load_serve  = 1'b1;
                    end
                    SERVE: begin
                        load_serve  = 1'b1;
                        serve_cnt_d = serve_cnt_q + 1'b1;
                        if (serve_cnt_d == C_SC_LAST) state_d = PLAY;
                    end
                    PLAY: begin
                        if (dir_y_q) begin
                            if (by + C_BS - 11'd1 + spd > C_WB) begin
                                ball_y_d = 10'(C_BALL_Y_MAX);
                                dir_y_d  = 1'b0;
                            end else begin
                                ball_y_d = 10'(by + spd);
                            end
                        end else if (by < C_WT + spd) begin
                            ball_y_d = 10'(C_WT);
                            dir_y_d  = 1'b1;
                        end else begin
                            ball_y_d = 10'(by - spd);
                        end

                        if (!dir_x_q) begin
                            if (bx >= C_L_FACE && bx - spd < C_L_FACE && l_ovl) begin
                                ball_x_d = 10'(C_L_FACE);
                                dir_x_d  = 1'b1;
                                l_hit_d  = 1'b1;
                                hit      = 1'b1;
                            end else if (bx < spd) begin
                                l_mis_d       = 1'b1;
                                serve_right_d = 1'b0;
                            end else begin
                                ball_x_d = 10'(bx - spd);
                            end
                        end else begin
                            if (bx + C_BS - 11'd1 <= C_R_FACE && bx + C_BS - 11'd1 + spd > C_R_FACE && r_ovl) begin
                                ball_x_d = 10'(C_R_LAND);
                                dir_x_d  = 1'b0;
                                r_hit_d  = 1'b1;
                                hit      = 1'b1;
                            end else if (bx + C_BS - 11'd1 + spd > C_X_EDGE) begin
                                r_mis_d       = 1'b1;
                                serve_right_d = 1'b1;
                            end else begin
                                ball_x_d = 10'(bx + spd);
                            end
                        end

                        if (l_mis_d || r_mis_d) begin
                            state_d     = SERVE;
                            serve_cnt_d = '0;
                            load_serve  = 1'b1;
                        end

                        if (hit) begin
                            if (hit_cnt_q == C_HC_LAST) begin
                                hit_cnt_d = '0;
                                if (speed_q < C_SPD_MAX) speed_d = speed_q + 3'd1;
                            end else begin
                                hit_cnt_d = hit_cnt_q + 1'b1;
                            end
                        end
                    end
                    default: state_d = IDLE;
                endcase

                if (load_serve) begin
                    ball_x_d  = 10'(C_BALL_X0);
                    ball_y_d  = 10'(C_BALL_Y0);
                    dir_x_d   = serve_right_d;
                    dir_y_d   = 1'b1;
                    speed_d   = C_SPD_INIT;
                    hit_cnt_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q       <= IDLE;
            ball_x_q      <= 10'(C_BALL_X0);
            ball_y_q      <= 10'(C_BALL_Y0);
            lpad_y_q      <= 10'(C_PAD_Y0);
            rpad_y_q      <= 10'(C_PAD_Y0);
            dir_x_q       <= 1'b0;
            dir_y_q       <= 1'b1;
            serve_right_q <= 1'b0;
            speed_q       <= C_SPD_INIT;
            hit_cnt_q     <= '0;
            serve_cnt_q   <= '0;
            l_hit_q       <= 1'b0;
            r_hit_q       <= 1'b0;
            l_mis_q       <= 1'b0;
            r_mis_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            ball_x_q      <= ball_x_d;
            ball_y_q      <= ball_y_d;
            lpad_y_q      <= lpad_y_d;
            rpad_y_q      <= rpad_y_d;
            dir_x_q       <= dir_x_d;
            dir_y_q       <= dir_y_d;
            serve_right_q <= serve_right_d;
            speed_q       <= speed_d;
            hit_cnt_q     <= hit_cnt_d;
            serve_cnt_q   <= serve_cnt_d;
            l_hit_q       <= l_hit_d;
            r_hit_q       <= r_hit_d;
            l_mis_q       <= l_mis_d;
            r_mis_q       <= r_mis_d;
        end
    end

    assign bus.ball_on = (px >= bx) && (px < bx + C_BS) && (py >= by) && (py < by + C_BS);
    assign bus.lpad_on = (px >= C_LPAD_X) && (px < C_LPAD_X + C_PW) && (py >= lp) && (py < lp + C_PH);
    assign bus.rpad_on = (px >= C_RPAD_X) && (px < C_RPAD_X + C_PW) && (py >= rp) && (py < rp + C_PH);
    assign bus.l_hit   = l_hit_q;
    assign bus.r_hit   = r_hit_q;
    assign bus.l_mis   = l_mis_q;
    assign bus.r_mis   = r_mis_q;
    assign bus.speed   = speed_q;
endmodule

// File: tb/tb_pong_physics.sv
// Directed bench: dut_a uses default geometry for serve/paddle/hit/miss vectors; dut_b uses
// full-height paddles so every arrival is a hit, exercising the speed-up and its ceiling.
module tb_pong_physics;
    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    pong_physics_if bus_a ();
    pong_physics_if bus_b ();

    pong_physics dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    pong_physics #(.PAD_H(404)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick_a();
        bus_a.x = 10'd0;
        bus_a.y = 10'd481;
        @(posedge clk);
        #1;
        bus_a.y = 10'd0;
    endtask

    task automatic tick_b();
        bus_b.x = 10'd0;
        bus_b.y = 10'd481;
        @(posedge clk);
        #1;
        bus_b.y = 10'd0;
    endtask

    function automatic int pulses_a();
        return int'(bus_a.l_hit | bus_a.r_hit | bus_a.l_mis | bus_a.r_mis);
    endfunction

    task automatic ticks_a(input int n, inout int pulses);
        for (int i = 0; i < n; i++) begin
            tick_a();
            pulses += pulses_a();
        end
    endtask

    task automatic pix_a(input int px, input int py);
        bus_a.x = 10'(px);
        bus_a.y = 10'(py);
        #1;
    endtask

    task automatic check_ball_a(input string tag, input int bx, input int by);
        pix_a(bx, by);         check({tag, ".tl"}, int'(bus_a.ball_on), 1);
        pix_a(bx + 7, by + 7); check({tag, ".br"}, int'(bus_a.ball_on), 1);
        pix_a(bx + 8, by);     check({tag, ".r"},  int'(bus_a.ball_on), 0);
        pix_a(bx, by + 8);     check({tag, ".b"},  int'(bus_a.ball_on), 0);
    endtask

    initial begin
        int pulses;
        int hits;
        int misses;
        int exp_spd;

        reset           = 1'b1;
        bus_a.btn       = 4'b0000;
        bus_a.gra_still = 1'b1;
        bus_a.x         = 10'd0;
        bus_a.y         = 10'd0;
        bus_b.btn       = 4'b0000;
        bus_b.gra_still = 1'b0;
        bus_b.x         = 10'd0;
        bus_b.y         = 10'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state.
        check_ball_a("rst.ball", 316, 270);
        pix_a(32, 224);  check("rst.lpad_top", int'(bus_a.lpad_on), 1);
        pix_a(32, 223);  check("rst.lpad_above", int'(bus_a.lpad_on), 0);
        pix_a(38, 323);  check("rst.lpad_bot", int'(bus_a.lpad_on), 1);
        pix_a(38, 324);  check("rst.lpad_below", int'(bus_a.lpad_on), 0);
        pix_a(39, 224);  check("rst.lpad_rcol", int'(bus_a.lpad_on), 0);
        pix_a(600, 224); check("rst.rpad_top", int'(bus_a.rpad_on), 1);
        check("rst.speed", int'(bus_a.speed), 1);
        check("rst.pulses", pulses_a(), 0);

        // Right paddle up to the wall, then both buttons hold it; ball frozen by gra_still.
        pulses = 0;
        bus_a.btn = 4'b0001;
        ticks_a(50, pulses);
        pix_a(600, 72);  check("rpad.top", int'(bus_a.rpad_on), 1);
        pix_a(600, 71);  check("rpad.above", int'(bus_a.rpad_on), 0);
        pix_a(606, 171); check("rpad.bot", int'(bus_a.rpad_on), 1);
        pix_a(606, 172); check("rpad.below", int'(bus_a.rpad_on), 0);
        bus_a.btn = 4'b0011;
        ticks_a(5, pulses);
        pix_a(600, 72);  check("rpad.both_top", int'(bus_a.rpad_on), 1);
        pix_a(606, 172); check("rpad.both_below", int'(bus_a.rpad_on), 0);
        check_ball_a("still.ball", 316, 270);
        check("still.pulses", pulses, 0);

        // Serve: 60 ticks static, first move on tick 61. Left paddle driven down to its floor.
        bus_a.btn = 4'b1000;
        bus_a.gra_still = 1'b0;
        ticks_a(60, pulses);
        check_ball_a("serve60", 316, 270);
        pix_a(32, 376);  check("lpad.floor_top", int'(bus_a.lpad_on), 1);
        pix_a(32, 375);  check("lpad.floor_above", int'(bus_a.lpad_on), 0);
        pix_a(38, 475);  check("lpad.floor_bot", int'(bus_a.lpad_on), 1);
        ticks_a(1, pulses);
        check_ball_a("play1", 315, 271);

        // Bottom wall: y=468 after play tick 198, held at 468 on 199, then up.
        ticks_a(197, pulses);
        check_ball_a("play198", 118, 468);
        ticks_a(1, pulses);
        check_ball_a("play199", 117, 468);
        ticks_a(1, pulses);
        check_ball_a("play200", 116, 467);
        ticks_a(77, pulses);
        check_ball_a("play277", 39, 390);
        check("play.no_pulse", pulses, 0);

        // Left paddle hit at x=39.
        tick_a();
        check("lhit.pulse", int'(bus_a.l_hit), 1);
        check("lhit.rhit", int'(bus_a.r_hit), 0);
        @(posedge clk);
        #1;
        check("lhit.clear", int'(bus_a.l_hit), 0);
        check_ball_a("lhit.ball", 39, 389);
        tick_a();
        check_ball_a("lhit.dir_right", 40, 388);
        check("lhit.speed", int'(bus_a.speed), 1);

        // gra_still mid-play: back to IDLE, ball re-centred, no pulses.
        bus_a.btn = 4'b0100;
        bus_a.gra_still = 1'b1;
        tick_a();
        check("still.no_pulse", pulses_a(), 0);
        check_ball_a("still.center", 316, 270);
        tick_a();
        check_ball_a("still.hold", 316, 270);

        // Re-serve with the left paddle parked at the top: ball passes below and misses.
        pulses = 0;
        bus_a.gra_still = 1'b0;
        ticks_a(60, pulses);
        ticks_a(316, pulses);
        check("miss.no_early_pulse", pulses, 0);
        check_ball_a("miss.edge", 0, 351);
        tick_a();
        check("lmis.pulse", int'(bus_a.l_mis), 1);
        check("lmis.lhit", int'(bus_a.l_hit), 0);
        check("lmis.speed", int'(bus_a.speed), 1);
        @(posedge clk);
        #1;
        check("lmis.clear", int'(bus_a.l_mis), 0);
        check_ball_a("lmis.center", 316, 270);
        pix_a(32, 72);  check("lpad.ceil_top", int'(bus_a.lpad_on), 1);
        pix_a(32, 172); check("lpad.ceil_below", int'(bus_a.lpad_on), 0);
        pulses = 0;
        ticks_a(5, pulses);
        check_ball_a("serve.hold", 316, 270);
        check("serve.no_pulse", pulses, 0);

        // Speed-up: full-height paddles, count hits and check the speed ladder.
        hits   = 0;
        misses = 0;
        for (int f = 0; f < 20000 && hits < 28; f++) begin
            tick_b();
            if (bus_b.l_mis || bus_b.r_mis) misses++;
            if (bus_b.l_hit || bus_b.r_hit) begin
                hits++;
                exp_spd = -1;
                case (hits)
                    1:  begin exp_spd = 1; check("spd.first_is_left", int'(bus_b.l_hit), 1); end
                    3:  exp_spd = 1;
                    4:  exp_spd = 2;
                    7:  exp_spd = 2;
                    8:  exp_spd = 3;
                    20: exp_spd = 6;
                    24: exp_spd = 6;
                    28: exp_spd = 6;
                    default: exp_spd = -1;
                endcase
                if (exp_spd >= 0) check($sformatf("spd.hit%0d", hits), int'(bus_b.speed), exp_spd);
            end
        end
        check("spd.hits", hits, 28);
        check("spd.misses", misses, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
